// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative RV32M multiply/divide unit with start/busy/done handshake
module mdu_iter #(
    parameter int CPU_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mdu_start,
    input  logic                 mdu_flush,
    input  logic [2:0]           mdu_op,
    input  logic [CPU_WIDTH-1:0] alu_src1,
    input  logic [CPU_WIDTH-1:0] alu_src2,
    output logic                 mdu_busy,
    output logic                 mdu_done,
    output logic [CPU_WIDTH-1:0] mdu_result
);

    localparam int W  = CPU_WIDTH;
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST_ITER = CW'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic [2:0]       r_op;
    logic             r_n1;
    logic             r_n2;
    logic             r_div0;
    logic             r_ovf;
    logic [W-1:0]     r_b;
    logic [2*W-1:0]   r_acc;
    logic [CW-1:0]    r_cnt;
    logic [W-1:0]     r_result;

    logic             w_accept;
    logic             w_is_div;
    logic             w_s1_signed;
    logic             w_s2_signed;
    logic             w_n1;
    logic             w_n2;
    logic [W-1:0]     w_mag1;
    logic [W-1:0]     w_mag2;
    logic             w_div0;
    logic             w_ovf;

    logic [W:0]       w_mul_sum;
    logic [2*W-1:0]   w_mul_next;
    logic [W:0]       w_div_trial;
    logic [2*W-1:0]   w_div_next;

    logic [2*W-1:0]   w_prod;
    logic [W-1:0]     w_mul_res;
    logic [W-1:0]     w_quo;
    logic [W-1:0]     w_rem;
    logic [W-1:0]     w_final;

    // Operand decode: signedness per funct3, magnitudes and special-case flags captured on accept
    assign w_accept    = (r_state == S_IDLE) && mdu_start && !mdu_flush;
    assign w_is_div    = mdu_op[2];
    assign w_s1_signed = w_is_div ? !mdu_op[0] : (mdu_op[1:0] != 2'b11);
    assign w_s2_signed = w_is_div ? !mdu_op[0] : !mdu_op[1];
    assign w_n1        = w_s1_signed && alu_src1[W-1];
    assign w_n2        = w_s2_signed && alu_src2[W-1];
    assign w_mag1      = w_n1 ? -alu_src1 : alu_src1;
    assign w_mag2      = w_n2 ? -alu_src2 : alu_src2;
    assign w_div0      = (alu_src2 == '0);
    assign w_ovf       = w_s1_signed && (alu_src1 == {1'b1, {(W-1){1'b0}}}) && (&alu_src2);

    // Shift-add step: add multiplicand into the high half when multiplier lsb is set, then shift right
    assign w_mul_sum   = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_b} : {(W+1){1'b0}});
    assign w_mul_next  = {w_mul_sum, r_acc[W-1:1]};

    // Restoring step: high half is the partial remainder, low half shifts dividend out and quotient in
    assign w_div_trial = r_acc[2*W-1:W-1] - {1'b0, r_b};
    assign w_div_next  = w_div_trial[W] ? {r_acc[2*W-2:0], 1'b0}
                                        : {w_div_trial[W-1:0], r_acc[W-2:0], 1'b1};

    // Sign fix-up of the magnitude results
    assign w_prod    = (r_n1 ^ r_n2) ? -r_acc : r_acc;
    assign w_mul_res = (r_op[1:0] == 2'b00) ? w_prod[W-1:0] : w_prod[2*W-1:W];
    assign w_quo     = (r_n1 ^ r_n2) ? -r_acc[W-1:0] : r_acc[W-1:0];
    assign w_rem     = r_n1 ? -r_acc[2*W-1:W] : r_acc[2*W-1:W];

    // Final result selection including divide-by-zero and signed overflow
    always_comb begin
        w_final = w_mul_res;
        if (r_op[2]) begin
            if (r_div0) begin
                w_final = r_op[1] ? w_rem : {W{1'b1}};
            end else if (r_ovf) begin
                w_final = r_op[1] ? {W{1'b0}} : {1'b1, {(W-1){1'b0}}};
            end else begin
                w_final = r_op[1] ? w_rem : w_quo;
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; flush returns to IDLE from any busy state
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = S_CALC;
            S_CALC: begin
                if (mdu_flush) begin
                    w_next = S_IDLE;
                end else if (r_cnt == LAST_ITER) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign mdu_busy   = (r_state != S_IDLE);
    assign mdu_done   = (r_state == S_DONE) && !mdu_flush;
    assign mdu_result = mdu_done ? w_final : r_result;

    // Datapath: latch on accept, iterate in CALC, capture the result in an unflushed DONE
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op     <= '0;
            r_n1     <= 1'b0;
            r_n2     <= 1'b0;
            r_div0   <= 1'b0;
            r_ovf    <= 1'b0;
            r_b      <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            if (w_accept) begin
                r_op   <= mdu_op;
                r_n1   <= w_n1;
                r_n2   <= w_n2;
                r_div0 <= w_div0;
                r_ovf  <= w_ovf;
                r_b    <= w_is_div ? w_mag2 : w_mag1;
                r_acc  <= {{W{1'b0}}, (w_is_div ? w_mag1 : w_mag2)};
                r_cnt  <= '0;
            end else if ((r_state == S_CALC) && !mdu_flush) begin
                r_acc  <= r_op[2] ? w_div_next : w_mul_next;
                r_cnt  <= r_cnt + 1'b1;
            end
            if (mdu_done) begin
                r_result <= w_final;
            end
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// tb/tb_mdu_iter.sv - randomized self-checking bench for mdu_iter against an arithmetic model
module tb_mdu_iter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         mdu_start = 1'b0;
    logic         mdu_flush = 1'b0;
    logic [2:0]   mdu_op = 3'd0;
    logic [W-1:0] alu_src1 = '0;
    logic [W-1:0] alu_src2 = '0;
    logic         mdu_busy;
    logic         mdu_done;
    logic [W-1:0] mdu_result;

    int n_checks = 0;
    int n_fail   = 0;

    mdu_iter #(.CPU_WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mdu_start  (mdu_start),
        .mdu_flush  (mdu_flush),
        .mdu_op     (mdu_op),
        .alu_src1   (alu_src1),
        .alu_src2   (alu_src2),
        .mdu_busy   (mdu_busy),
        .mdu_done   (mdu_done),
        .mdu_result (mdu_result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // RV32M semantics computed with 64-bit integer arithmetic
    function automatic logic [31:0] ref_mdu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      ub;
        longint      q;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'b0, b});
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                q = sa / sb; p = q; return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                q = sa % sb; p = q; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'($urandom_range(0, 50));
            4: return -32'($urandom_range(1, 50));
            default: return $urandom;
        endcase
    endfunction

    task automatic scramble_inputs();
        mdu_op   = 3'($urandom);
        alu_src1 = $urandom;
        alu_src2 = $urandom;
    endtask

    // Present a request for one cycle; returns at #1 after the accepting edge
    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        mdu_op    = op;
        alu_src1  = a;
        alu_src2  = b;
        mdu_start = 1'b1;
        @(posedge clk);
        #1;
        mdu_start = 1'b0;
        scramble_inputs();
        check("busy_after_accept", {31'b0, mdu_busy}, 32'd1);
    endtask

    // Count edges after acceptance until done is seen, bounded
    task automatic wait_done(input int already, output int lat);
        lat = already;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!mdu_done && lat < 100);
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int          lat;
        logic [31:0] exp;
        exp = ref_mdu(op, a, b);
        start_op(op, a, b);
        wait_done(0, lat);
        check({tag, "_latency"}, lat, W);
        check({tag, "_result"}, mdu_result, exp);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, {31'b0, mdu_done}, 32'd0);
        check({tag, "_hold"}, mdu_result, exp);
    endtask

    task automatic watch_no_done(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (mdu_done) seen = 1;
        end
        check(tag, seen, 0);
    endtask

    initial begin
        int          lat;
        logic [31:0] prior;
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {31'b0, mdu_busy}, 32'd0);
        check("reset_done", {31'b0, mdu_done}, 32'd0);
        check("reset_result", mdu_result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("mul_7_m3",      3'd0, 32'h00000007, 32'hFFFFFFFD);
        run_op("mulh_7_m3",     3'd1, 32'h00000007, 32'hFFFFFFFD);
        run_op("mulhu_7_m3",    3'd3, 32'h00000007, 32'hFFFFFFFD);
        run_op("mulhsu_ones",   3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_op("mulhu_ones",    3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_op("div_m20_3",     3'd4, -32'd20,      32'd3);
        run_op("rem_m20_3",     3'd6, -32'd20,      32'd3);
        run_op("divu_20_3",     3'd5, 32'd20,       32'd3);
        run_op("remu_20_3",     3'd7, 32'd20,       32'd3);
        run_op("div_by_zero",   3'd4, 32'd5,        32'd0);
        run_op("remu_by_zero",  3'd7, 32'd5,        32'd0);
        run_op("rem_neg_by_0",  3'd6, 32'h80000000, 32'd0);
        run_op("div_overflow",  3'd4, 32'h80000000, 32'hFFFFFFFF);
        run_op("rem_overflow",  3'd6, 32'h80000000, 32'hFFFFFFFF);

        // Reset asserted mid-CALC at cycle 10
        start_op(3'd0, 32'd7, 32'hFFFFFFFD);
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midcalc_reset_busy", {31'b0, mdu_busy}, 32'd0);
        check("midcalc_reset_done", {31'b0, mdu_done}, 32'd0);
        check("midcalc_reset_result", mdu_result, 32'd0);
        rst_n = 1'b1;
        watch_no_done("midcalc_reset_no_done", 40);

        // Second start while busy is ignored
        start_op(3'd4, -32'd20, 32'd3);
        repeat (5) @(posedge clk);
        #1;
        mdu_op    = 3'd3;
        alu_src1  = 32'h12345678;
        alu_src2  = 32'h9ABCDEF0;
        mdu_start = 1'b1;
        @(posedge clk);
        #1;
        mdu_start = 1'b0;
        wait_done(6, lat);
        check("busy_start_latency", lat, W);
        check("busy_start_result", mdu_result, 32'hFFFFFFFA);
        @(posedge clk);
        #1;
        prior = 32'hFFFFFFFA;

        // Flush during CALC at cycle 15
        start_op(3'd5, 32'd1000, 32'd7);
        repeat (14) @(posedge clk);
        #1;
        mdu_flush = 1'b1;
        @(posedge clk);
        #1;
        mdu_flush = 1'b0;
        check("flush_idle", {31'b0, mdu_busy}, 32'd0);
        check("flush_result_kept", mdu_result, prior);
        watch_no_done("flush_no_done", 40);
        check("flush_result_still", mdu_result, prior);

        // Flush together with start in IDLE: not accepted
        @(negedge clk);
        mdu_start = 1'b1;
        mdu_flush = 1'b1;
        @(posedge clk);
        #1;
        mdu_start = 1'b0;
        mdu_flush = 1'b0;
        check("flush_start_rejected", {31'b0, mdu_busy}, 32'd0);

        // Start during DONE ignored, start in the following cycle accepted
        start_op(3'd1, 32'h80000000, 32'h80000000);
        wait_done(0, lat);
        check("b2b_first_latency", lat, W);
        check("b2b_first_result", mdu_result, 32'h40000000);
        mdu_op    = 3'd7;
        alu_src1  = 32'd100;
        alu_src2  = 32'd9;
        mdu_start = 1'b1;
        @(posedge clk);
        #1;
        check("b2b_start_in_done_ignored", {31'b0, mdu_busy}, 32'd0);
        @(posedge clk);
        #1;
        mdu_start = 1'b0;
        scramble_inputs();
        check("b2b_accepted", {31'b0, mdu_busy}, 32'd1);
        wait_done(0, lat);
        check("b2b_second_latency", lat, W);
        check("b2b_second_result", mdu_result, 32'd1);
        @(posedge clk);
        #1;

        // Randomized operations against the model
        for (int i = 0; i < 48; i++) begin
            rop = 3'($urandom);
            ra  = pick_operand();
            rb  = pick_operand();
            run_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Iterative RV32M multiply/divide unit at the execute stage.
- Consumes the same alu_src1/alu_src2 operand pair the ALU operand select produces; returns one CPU_WIDTH result for writeback.
- Multi-cycle with a start/busy/done handshake; the decode/hazard logic stalls the pipeline while mdu_busy is high.

Parameters:
- CPU_WIDTH, 32, operand/result width; iteration count equals CPU_WIDTH.

Ports:
- clk  input  1  core clock, all state updates on rising edge
- rst_n  input  1  synchronous active-low reset
- mdu_start  input  1  request; accepted only in IDLE
- mdu_flush  input  1  pipeline flush; aborts any operation
- mdu_op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- alu_src1  input  CPU_WIDTH  rs1 operand (multiplicand/dividend), sampled on accept
- alu_src2  input  CPU_WIDTH  rs2 operand (multiplier/divisor), sampled on accept
- mdu_busy  output  1  high in CALC and DONE
- mdu_done  output  1  one-cycle pulse, mdu_result valid
- mdu_result  output  CPU_WIDTH  result, held until next accepted start

Behaviour:
- Clock and reset: one clock clk. Reset is synchronous, active-low on rst_n.
- Reset values: state=IDLE, mdu_busy=0, mdu_done=0, mdu_result=0, all internal registers 0.
- Reset has priority over every other input, including mid-operation.
- States:
  - IDLE: waits for mdu_start.
  - CALC: runs CPU_WIDTH iterations, counter counts 0..CPU_WIDTH-1.
  - DONE: one cycle, drives mdu_done=1 and a registered mdu_result.
- Transitions:
  - IDLE -> CALC on mdu_start && !mdu_flush. op, operand magnitudes and sign flags are latched on this edge.
  - CALC -> DONE when counter==CPU_WIDTH-1.
  - DONE -> IDLE unconditionally.
- Latency: start accepted at edge 0, mdu_done high during cycle CPU_WIDTH+1 (33 for default). The latency is fixed for all ops and special cases.
- mdu_start while busy is ignored. Operands and op may change freely after acceptance.
- mdu_start and mdu_done in the same cycle: the start is ignored. A back-to-back start is accepted only the cycle after DONE.
- mdu_flush in CALC or DONE: next state IDLE, mdu_done forced 0 that cycle, mdu_result unchanged.
- mdu_flush with mdu_start in IDLE: flush wins, the request is not accepted.
- Multiply:
  - Shift-add over 2*CPU_WIDTH accumulator using unsigned magnitudes.
  - Product negated at DONE if the result sign is negative.
  - MUL returns low half. MULH is signed x signed, high half. MULHSU is signed src1 x unsigned src2, high half. MULHU is unsigned, high half.
- Divide:
  - Restoring, one quotient bit per iteration, on magnitudes.
  - Quotient is negated when the operand signs differ (signed ops).
  - Remainder takes the sign of the dividend.
- Special cases, resolved at DONE with no trap and the same latency:
  - Divide by zero: DIV/DIVU -> all ones; REM/REMU -> alu_src1.
  - Signed overflow (src1=0x80000000, src2=0xFFFFFFFF): DIV -> 0x80000000, REM -> 0.
- mdu_result updates only in DONE and holds until the next DONE.

Test Plan:
- Reset with rst_n=0 mid-CALC (cycle 10) -> next edge busy=0, done=0, result=0; no done pulse follows.
- MUL 7 x -3 (0x00000007, 0xFFFFFFFD) -> done at cycle 33, result 0xFFFFFFEB. MULH on the same operands -> 0xFFFFFFFF. MULHU on the same operands -> 0x00000006.
- MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
- DIV -20/3 -> 0xFFFFFFFA (-6). REM -20/3 -> 0xFFFFFFFE (-2). DIVU 20/3 -> 6. REMU 20/3 -> 2.
- Corner cases:
  - DIV 5/0 -> 0xFFFFFFFF.
  - REMU 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
  - REM on the same operands -> 0.
- Handshake:
  - Second start asserted during CALC is ignored; result is that of the first op.
  - Flush at cycle 15 -> IDLE next cycle, no done, prior result retained.
  - Start in the cycle after DONE is accepted; its done arrives 33 cycles later.
